// File: rtl/ysyx_22040895_ifetch.sv
// Instruction-fetch bus master: one read per PC, picks 32-bit half of 64-bit beat, hands it to the IFU.
// Latency: pc accept -> inst_valid_o in 3 cycles best case (1 cycle for misaligned PC).
// Backpressure: pc_ready_o only in IDLE; request held until req_ready_i; instruction held until inst_ready_i.
module ysyx_22040895_ifetch #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_ready_o,
    input  logic              redirect_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              resp_valid_i,
    input  logic [DATA_W-1:0] resp_data_i,
    input  logic              resp_err_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [1:0]        fault_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_OK    = 2'b00;
    localparam logic [1:0] FAULT_ALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS   = 2'b10;

    state_t             state_q, state_d;
    logic               kill_q, kill_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic [1:0]         fault_q, fault_d;
    logic [INST_W-1:0]  resp_inst;

    // pc[2] chooses which instruction of the two-instruction beat is ours.
    assign resp_inst = pc_q[2] ? resp_data_i[INST_W +: INST_W] : resp_data_i[0 +: INST_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            pc_q    <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= FAULT_OK;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (pc_valid_i && !redirect_i) begin
                    pc_d   = pc_i;
                    addr_d = {pc_i[ADDR_W-1:3], 3'b000};
                    if (pc_i[1:0] != 2'b00) begin
                        inst_d  = '0;
                        fault_d = FAULT_ALIGN;
                        state_d = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // A request already on the bus cannot be withdrawn; remember to drop its data.
                if (redirect_i) begin
                    kill_d = 1'b1;
                end
                if (req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid_i) begin
                    kill_d  = 1'b0;
                    state_d = IDLE;
                    if (!kill_q && !redirect_i) begin
                        inst_d  = resp_err_i ? '0 : resp_inst;
                        fault_d = resp_err_i ? FAULT_BUS : FAULT_OK;
                        state_d = HOLD;
                    end
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                // Redirect wins over a same-cycle consume; the core flushes that instruction.
                if (redirect_i || inst_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    assign pc_ready_o   = (state_q == IDLE);
    assign req_valid_o  = (state_q == REQ);
    assign inst_valid_o = (state_q == HOLD);
    assign req_addr_o   = addr_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_ysyx_22040895_ifetch.sv
// Directed bench for ysyx_22040895_ifetch with an expected-instruction queue checked on IFU handshakes.
module tb_ysyx_22040895_ifetch;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pc_valid_i = 1'b0;
    logic [AW-1:0] pc_i = '0;
    logic          pc_ready_o;
    logic          redirect_i = 1'b0;
    logic          req_valid_o;
    logic          req_ready_i = 1'b0;
    logic [AW-1:0] req_addr_o;
    logic          resp_valid_i = 1'b0;
    logic [DW-1:0] resp_data_i = '0;
    logic          resp_err_i = 1'b0;
    logic          inst_valid_o;
    logic          inst_ready_i = 1'b0;
    logic [IW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic [1:0]    fault_o;

    ysyx_22040895_ifetch #(.ADDR_W(AW), .DATA_W(DW), .INST_W(IW)) dut (
        .clk(clk), .rst(rst),
        .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_ready_o(pc_ready_o),
        .redirect_i(redirect_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_err_i(resp_err_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
        logic [1:0]    fault;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted instruction must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && inst_valid_o && inst_ready_i && !redirect_i) begin
            if (sb.size() == 0) begin
                chk("stray_inst", 64'(inst_valid_o), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("inst", 64'(inst_o), 64'(mon_e.inst));
                chk("inst_pc", inst_pc_o, mon_e.pc);
                chk("fault", 64'(fault_o), 64'(mon_e.fault));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pc_ready"}, 64'(pc_ready_o), 64'd1);
        chk({tag, "_req_valid"}, 64'(req_valid_o), 64'd0);
        chk({tag, "_req_addr"}, req_addr_o, 64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid_o), 64'd0);
        chk({tag, "_inst"}, 64'(inst_o), 64'd0);
        chk({tag, "_inst_pc"}, inst_pc_o, 64'd0);
        chk({tag, "_fault"}, 64'(fault_o), 64'd0);
    endtask

    // Full fetch from IDLE; starts and ends just after a rising edge.
    task automatic fetch(input logic [AW-1:0] pc, input logic [DW-1:0] data, input logic err,
                         input int req_dly, input int ready_dly);
        exp_t          x;
        logic [AW-1:0] a;
        int            n;
        a       = {pc[AW-1:3], 3'b000};
        x.pc    = pc;
        x.fault = (pc[1:0] != 2'b00) ? 2'b01 : (err ? 2'b10 : 2'b00);
        x.inst  = (x.fault != 2'b00) ? 32'h0 : (pc[2] ? data[63:32] : data[31:0]);
        n = 0;
        while (!pc_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk("pc_ready_idle", 64'(pc_ready_o), 64'd1);
        sb.push_back(x);
        pc_valid_i   = 1'b1;
        pc_i         = pc;
        req_ready_i  = (req_dly == 0);
        if (pc[1:0] != 2'b00) begin
            inst_ready_i = (ready_dly == 0);
            tick();
            pc_valid_i = 1'b0;
            @(negedge clk);
            chk("mis_no_req", 64'(req_valid_o), 64'd0);
            chk("mis_valid_lat", 64'(inst_valid_o), 64'd1);
        end else begin
            tick();
            pc_valid_i = 1'b0;
            for (int i = 0; i <= req_dly; i++) begin
                if (i == req_dly) req_ready_i = 1'b1;
                @(negedge clk);
                chk("req_valid", 64'(req_valid_o), 64'd1);
                chk("req_addr", req_addr_o, a);
                chk("pc_ready_busy", 64'(pc_ready_o), 64'd0);
                tick();
            end
            req_ready_i  = 1'b0;
            resp_valid_i = 1'b1;
            resp_data_i  = data;
            resp_err_i   = err;
            inst_ready_i = (ready_dly == 0);
            tick();
            resp_valid_i = 1'b0;
            resp_err_i   = 1'b0;
            @(negedge clk);
            chk("inst_valid_lat", 64'(inst_valid_o), 64'd1);
        end
        for (int i = 0; i < ready_dly; i++) begin
            chk("hold_valid", 64'(inst_valid_o), 64'd1);
            chk("hold_inst", 64'(inst_o), 64'(x.inst));
            chk("hold_pc_ready", 64'(pc_ready_o), 64'd0);
            tick();
            if (i == ready_dly - 1) inst_ready_i = 1'b1;
            @(negedge clk);
        end
        tick();
        inst_ready_i = 1'b0;
        @(negedge clk);
        chk("consumed", 64'(inst_valid_o), 64'd0);
        chk("back_idle", 64'(pc_ready_o), 64'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        tick();
        rst = 1'b1;

        // Aligned fetches, low and high halves, zero-wait
        fetch(64'h8000_0000, 64'h00100093_00000413, 1'b0, 0, 0);
        fetch(64'h8000_0004, 64'h00100093_00000413, 1'b0, 0, 0);

        // Request and instruction backpressure
        fetch(64'h8000_0008, 64'hCAFEF00D_12345678, 1'b0, 3, 2);

        // Redirect in WAIT without response: late data must be dropped
        inst_ready_i = 1'b1;
        pc_valid_i   = 1'b1;
        pc_i         = 64'h8000_000C;
        req_ready_i  = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        tick();
        req_ready_i = 1'b0;
        redirect_i  = 1'b1;
        tick();
        redirect_i = 1'b0;
        tick();
        resp_valid_i = 1'b1;
        resp_data_i  = 64'hDEADBEEF_DEADBEEF;
        tick();
        resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("kill_wait_no_inst", 64'(inst_valid_o), 64'd0);
            tick();
        end
        inst_ready_i = 1'b0;
        chk("kill_wait_idle", 64'(pc_ready_o), 64'd1);
        fetch(64'h8000_0010, 64'h11111111_22222222, 1'b0, 0, 0);

        // Redirect in REQ: request stays up, response dropped
        inst_ready_i = 1'b1;
        pc_valid_i   = 1'b1;
        pc_i         = 64'h8000_0030;
        tick();
        pc_valid_i = 1'b0;
        redirect_i = 1'b1;
        tick();
        redirect_i  = 1'b0;
        req_ready_i = 1'b1;
        @(negedge clk);
        chk("req_not_withdrawn", 64'(req_valid_o), 64'd1);
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        resp_data_i  = 64'hBAD0BAD0_BAD0BAD0;
        tick();
        resp_valid_i = 1'b0;
        @(negedge clk);
        chk("kill_req_no_inst", 64'(inst_valid_o), 64'd0);
        chk("kill_req_idle", 64'(pc_ready_o), 64'd1);
        tick();
        inst_ready_i = 1'b0;

        // Redirect together with response in WAIT: dropped, no lingering kill
        pc_valid_i  = 1'b1;
        pc_i        = 64'h8000_0038;
        req_ready_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
        tick();
        req_ready_i  = 1'b0;
        resp_valid_i = 1'b1;
        redirect_i   = 1'b1;
        resp_data_i  = 64'h55555555_66666666;
        tick();
        resp_valid_i = 1'b0;
        redirect_i   = 1'b0;
        @(negedge clk);
        chk("redir_resp_no_inst", 64'(inst_valid_o), 64'd0);
        chk("redir_resp_idle", 64'(pc_ready_o), 64'd1);
        tick();
        fetch(64'h8000_0044, 64'h0badc0de_00a00513, 1'b0, 1, 0);

        // Misaligned PC and bus error
        fetch(64'h8000_0002, 64'h0, 1'b0, 0, 1);
        fetch(64'h8000_0018, 64'h00000013_00000013, 1'b1, 0, 0);

        // Reset in HOLD
        pc_valid_i = 1'b1;
        pc_i       = 64'h8000_0006;
        tick();
        pc_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_hold", 64'(inst_valid_o), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_reset_outputs("rst_hold");
        tick();
        rst = 1'b1;

        // Reset in REQ, then a stray response in IDLE
        pc_valid_i = 1'b1;
        pc_i       = 64'h8000_0020;
        tick();
        pc_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", 64'(req_valid_o), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk_reset_outputs("rst_req");
        tick();
        rst          = 1'b1;
        resp_valid_i = 1'b1;
        resp_data_i  = 64'h77777777_88888888;
        tick();
        resp_valid_i = 1'b0;
        @(negedge clk);
        chk("post_rst_resp_ignored", 64'(inst_valid_o), 64'd0);
        tick();

        // Redirect in HOLD with inst_ready_i high: no delivery
        pc_valid_i = 1'b1;
        pc_i       = 64'h8000_0021;
        tick();
        pc_valid_i   = 1'b0;
        redirect_i   = 1'b1;
        inst_ready_i = 1'b1;
        @(negedge clk);
        chk("redir_hold_valid", 64'(inst_valid_o), 64'd1);
        tick();
        redirect_i   = 1'b0;
        inst_ready_i = 1'b0;
        @(negedge clk);
        chk("redir_hold_dropped", 64'(inst_valid_o), 64'd0);
        chk("redir_hold_idle", 64'(pc_ready_o), 64'd1);
        tick();
        fetch(64'h8000_0050, 64'h00308093_00208093, 1'b0, 0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22040895_ifetch.md
# ysyx_22040895_ifetch

Instruction-fetch bus master sitting directly upstream of the IFU: accepts a fetch address from the PC register, issues a single read on the instruction memory bus, selects the 32-bit instruction from the 64-bit return beat, and presents it with its PC on a valid/ready port that drives the IFU's instruction input. One outstanding request at a time. Redirects (branch/jump taken) discard any in-flight or held fetch so a stale instruction never reaches the IFU.

## Interface
Parameters:
- ADDR_W, 64, fetch address / PC width
- DATA_W, 64, memory read data width (fixed two instructions per beat)
- INST_W, 32, instruction width

Ports:
- clk  in  1  core clock
- rst  in  1  one clock; reset is synchronous and active-low (rst=0 resets on the rising edge of clk)
- pc_valid_i  in  1  pc_i holds an address to fetch
- pc_i  in  ADDR_W  fetch address
- pc_ready_o  out  1  fetch address accepted this cycle when high with pc_valid_i
- redirect_i  in  1  control-flow change; kill current fetch
- req_valid_o  out  1  memory read request
- req_ready_i  in  1  memory accepts request
- req_addr_o  out  ADDR_W  8-byte aligned read address
- resp_valid_i  in  1  read data valid
- resp_data_i  in  DATA_W  read data
- resp_err_i  in  1  bus error with this response
- inst_valid_o  out  1  instruction available
- inst_ready_i  in  1  IFU consumes instruction
- inst_o  out  INST_W  instruction
- inst_pc_o  out  ADDR_W  address of inst_o
- fault_o  out  2  qualified by inst_valid_o: 00 ok, 01 misaligned, 10 bus error

## Operation
- States: IDLE, REQ, WAIT, HOLD, plus 1-bit kill flag.
- IDLE: pc_ready_o=1. pc_valid_i & !redirect_i: latch pc_i; if pc_i[1:0]!=0 -> HOLD with inst_o=0, fault_o=01, no bus request; else -> REQ.
- REQ: req_valid_o=1, req_addr_o={pc[ADDR_W-1:3],3'b000}; req_valid_o and req_addr_o stay stable until req_ready_i. Handshake -> WAIT.
- WAIT: resp_valid_i -> if kill: clear kill, -> IDLE (data dropped); else capture inst = pc[2] ? resp_data_i[63:32] : resp_data_i[31:0], fault_o = resp_err_i ? 10 : 00 (inst_o=0 on error), -> HOLD.
- HOLD: inst_valid_o=1, inst_o/inst_pc_o/fault_o stable. inst_ready_i -> IDLE.
- redirect_i:
  - IDLE: pc_valid_i ignored that cycle, stay IDLE.
  - REQ: request is not withdrawn; kill set; handshake still completes, then WAIT.
  - WAIT with resp_valid_i same cycle: response dropped, -> IDLE, kill stays 0. WAIT without response: kill set.
  - HOLD: inst_valid_o drops next cycle, -> IDLE, even if inst_ready_i is high the same cycle (the IFU's consumption is discarded by the core's flush).
- redirect_i while kill already set: no further effect.
- resp_valid_i outside WAIT: ignored.

## Timing
- Reset values: state IDLE, kill=0, pc_ready_o=1 (IDLE combinational), req_valid_o=0, req_addr_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, fault_o=00.
- pc_ready_o, req_valid_o, inst_valid_o are pure functions of state (registered); no combinational path from any input to any output except none — all outputs registered or state-decoded.
- Best case: pc accepted cycle 0 -> req_valid_o cycle 1 -> req_ready_i cycle 1 -> resp_valid_i cycle 2 -> inst_valid_o cycle 3. Throughput: one instruction per 4 cycles with zero-wait memory and immediate inst_ready_i.
- Misaligned: inst_valid_o one cycle after pc acceptance.
- Reset asserted in any state: next edge to IDLE, kill cleared; a response arriving after reset while in IDLE is ignored.

## Test plan
- Aligned fetch, pc_i=0x80000000, req_ready_i immediate, resp_data_i=0x00100093_00000413 one cycle later -> req_addr_o=0x80000000, inst_o=0x00000413, inst_pc_o=0x80000000, fault_o=00, inst_valid_o at cycle 3.
- pc_i=0x80000004, same data -> inst_o=0x00100093; req_addr_o=0x80000000.
- Backpressure: req_ready_i low 3 cycles, then inst_ready_i low 2 cycles -> req_valid_o/req_addr_o stable 4 cycles; inst_o stable, inst_valid_o high until consumed; pc_ready_o low throughout.
- Redirect in WAIT (no response), response 2 cycles later with 0xDEADBEEF -> inst_valid_o never asserts, returns to IDLE, next fetch 0x80000010 delivers correct data.
- pc_i=0x80000002 -> no req_valid_o, inst_valid_o next cycle, fault_o=01, inst_o=0; resp_err_i=1 on aligned fetch -> fault_o=10, inst_o=0.
- rst=0 asserted in HOLD and in REQ -> all outputs at reset values after one edge; redirect in HOLD with inst_ready_i=1 -> IDLE, no duplicate delivery.
